// File: rtl/div_ctrl.sv
// div_ctrl -- iterative radix-2 restoring divider controller for the E stage.
//
// Sequences one DIV/DIVU over WIDTH restoring steps and stalls the pipeline
// until the quotient (lo) and remainder (hi) are written. An exception flush
// (annul) aborts any operation without touching hi/lo.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             DIV/DIVU valid in E (held while stalled)
//   signed_div        1 = DIV, 0 = DIVU (sampled with start in IDLE)
//   opa, opb          dividend / divisor (sampled in IDLE)
//   annul             exception flush, highest priority
//   div_stall         combinational stall request to the hazard unit
//   result_valid      one-cycle pulse, hi/lo newly written
//   hi, lo            remainder / quotient (registered)
//   busy              state != IDLE
//
// Optional feature macro: DIV_ZERO_FASTPATH_EN -- a zero divisor skips the
// RUN phase and completes one cycle after acceptance.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] rem, quo, dvsr, opaRaw;
  logic [CW-1:0]    cnt;
  logic             sa, sb, divZero;

  logic [WIDTH:0]   remShift, trial;
  logic [WIDTH-1:0] remStep, quoStep, remFix, quoFix, magA, magB;
  logic             accept, lastStep, negA, negB;

  // Datapath: one restoring step plus the sign fix of its result.
  always_comb begin
    negA     = signed_div & opa[WIDTH-1];
    negB     = signed_div & opb[WIDTH-1];
    magA     = negA ? -opa : opa;
    magB     = negB ? -opb : opb;
    // {rem, quo} << 1 : rem picks up the quotient MSB
    remShift = {rem, quo[WIDTH-1]};
    // WIDTH+1 bits is enough: a negative result is always > -2^WIDTH and a
    // non-negative one always < 2^WIDTH, so bit WIDTH is the sign.
    trial    = remShift - {1'b0, dvsr};
    quoStep  = {quo[WIDTH-2:0], ~trial[WIDTH]};
    remStep  = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
    quoFix   = (sa ^ sb) ? -quoStep : quoStep;
    remFix   = sa ? -remStep : remStep;
  end

  assign accept   = (state == IDLE) & start & ~annul;
  assign lastStep = (state == RUN) & (cnt == CW'(WIDTH - 1));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) begin
`ifdef DIV_ZERO_FASTPATH_EN
        stateNext = (opb == '0) ? DONE : RUN;
`else
        stateNext = RUN;
`endif
      end
      RUN:  if (lastStep) stateNext = DONE;
      DONE: stateNext = IDLE;   // start still high here is the same instruction
      default: stateNext = IDLE;
    endcase
    if (annul) stateNext = IDLE;
  end

  assign div_stall    = start & ~annul & (state != DONE);
  assign result_valid = (state == DONE) & ~annul;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      opaRaw  <= '0;
      cnt     <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      divZero <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        sa      <= negA;
        sb      <= negB;
        quo     <= magA;
        dvsr    <= magB;
        rem     <= '0;
        cnt     <= '0;
        opaRaw  <= opa;
        divZero <= (opb == '0);
`ifdef DIV_ZERO_FASTPATH_EN
        if (opb == '0) begin
          hi <= opa;
          lo <= '1;
        end
`endif
      end else if ((state == RUN) && !annul) begin
        rem <= remStep;
        quo <= quoStep;
        cnt <= cnt + CW'(1);
        if (lastStep) begin
          // zero divisor: results are forced, not taken from the datapath
          hi <= divZero ? opaRaw : remFix;
          lo <= divZero ? '1     : quoFix;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  logic        clk = 0, rst, start, signed_div, annul;
  logic [31:0] opa, opb, hi, lo;
  logic        div_stall, result_valid, busy;
  int          nChk = 0, nFail = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opa(opa), .opb(opb), .annul(annul), .div_stall(div_stall),
    .result_valid(result_valid), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes
  // the dividend's sign); results wrap to 32 bits.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint la, lb, lq, lr;
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      la = sgn ? longint'($signed(a)) : longint'(a);
      lb = sgn ? longint'($signed(b)) : longint'(b);
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endtask

  // Entry/exit: #1 after a rising edge. Cycle 0 is the first cycle with start.
  task automatic runOp(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, input string tag);
    logic [31:0] eq, er;
    int doneAt, expAt;
    bit stallOk;
    model(sgn, a, b, eq, er);
    expAt = 33;
`ifdef DIV_ZERO_FASTPATH_EN
    if (b == 0) expAt = 1;
`endif
    signed_div = sgn; opa = a; opb = b; start = 1;
    doneAt = -1; stallOk = 1;
    for (int c = 0; c < 40 && doneAt < 0; c++) begin
      @(negedge clk);
      if (result_valid) begin
        doneAt = c;
        chk({tag, ".stallAtDone"}, 64'(div_stall), 64'd0);
      end else if (!div_stall) stallOk = 0;
      @(posedge clk); #1;
    end
    chk({tag, ".latency"}, 64'(doneAt), 64'(expAt));
    chk({tag, ".stallHeld"}, 64'(stallOk), 64'd1);
    chk({tag, ".lo"}, 64'(lo), 64'(eq));
    chk({tag, ".hi"}, 64'(hi), 64'(er));
    if (!hold) begin
      start = 0;
      @(negedge clk);
      chk({tag, ".idleAfter"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] pHi, pLo, ra, rb;
    logic rs;
    rst = 1; start = 0; annul = 0; signed_div = 0; opa = 0; opb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.valid", 64'(result_valid), 64'd0);
    chk("rst.stall", 64'(div_stall), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    runOp(0, 32'd100, 32'd7, 0, "divu100_7");
    runOp(1, 32'hFFFF_FFF9, 32'd2, 0, "div-7_2");
    runOp(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divOvf");
    runOp(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divuOvf");
    runOp(1, 32'h1234_5678, 32'd0, 0, "divZero");

    // annul at cycle 10
    pHi = hi; pLo = lo;
    signed_div = 0; opa = 32'd1000; opb = 32'd3; start = 1;
    repeat (10) @(posedge clk);
    #1 annul = 1;
    @(negedge clk);
    chk("annul.stall", 64'(div_stall), 64'd0);
    chk("annul.valid", 64'(result_valid), 64'd0);
    chk("annul.busyInCycle", 64'(busy), 64'd1);
    @(posedge clk); #1;
    annul = 0; start = 0;
    @(negedge clk);
    chk("annul.idle", 64'(busy), 64'd0);
    chk("annul.hiKept", 64'(hi), 64'(pHi));
    chk("annul.loKept", 64'(lo), 64'(pLo));
    @(posedge clk); #1;
    // annul together with start in IDLE
    start = 1; annul = 1;
    @(negedge clk);
    chk("annulIdle.stall", 64'(div_stall), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("annulIdle.noStart", 64'(busy), 64'd0);
    start = 0; annul = 0;
    @(posedge clk); #1;

    // back-to-back: start held through DONE, next op at cycle 34
    runOp(0, 32'd50, 32'd6, 1, "b2b.first");
    runOp(0, 32'd9, 32'd3, 0, "b2b.second");

    // reset at cycle 20
    signed_div = 0; opa = 32'd77; opb = 32'd5; start = 1;
    repeat (20) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    @(negedge clk);
    chk("midRst.busy", 64'(busy), 64'd0);
    chk("midRst.hi", 64'(hi), 64'd0);
    chk("midRst.lo", 64'(lo), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
      runOp(rs, ra, rb, 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
